// File: rtl/lane_result_tx_pkg.sv
// Shared types and constants for the lane result transmitter.
// LANE_TX_CHECKSUM_EN selects the 5-byte frame with trailing checksum;
// when undefined the frame is 4 bytes and no checksum logic is built.
package lane_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_SEQ,
    ST_CENTER,
    ST_CONF,
    ST_CSUM
  } tx_state_t;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

`ifdef LANE_TX_CHECKSUM_EN
  localparam int unsigned FRAME_LEN = 5;
`else
  localparam int unsigned FRAME_LEN = 4;
`endif

  typedef struct packed {
    logic [7:0] center;
    logic [7:0] conf;
  } lane_result_t;

endpackage

// File: rtl/lane_result_tx_fifo.sv
// Synchronous show-ahead FIFO of lane results. A push while full is
// accepted only when a pop happens in the same cycle.
module lane_result_fifo
  import lane_tx_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  lane_result_t             wr_data,
  output lane_result_t             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  lane_result_t mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/lane_result_tx.sv
// Lane result return-path transmitter: buffers {center, conf} results and
// serializes each as a framed byte packet on a valid/ready byte stream.
// Build option: LANE_TX_CHECKSUM_EN appends a CSUM byte (SEQ+CENTER+CONF).
module lane_result_tx
  import lane_tx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  SOF_BYTE   = SOF_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       result_valid,
  input  logic [7:0] result_center,
  input  logic [7:0] result_conf,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       overflow,
  output logic [7:0] drop_count
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  tx_state_t    state;
  lane_result_t frame;
  lane_result_t head;
  logic [7:0]   seq;
  logic         full;
  logic         empty;
  logic [LW-1:0] level;
  logic [LW-1:0] level_next;
  logic         accept;
  logic         frame_end;
  logic         pop;
  logic         wr_acc;
  logic         tx_valid_next;

  lane_result_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (result_valid),
    .pop    (pop),
    .wr_data({result_center, result_conf}),
    .rd_data(head),
    .full   (full),
    .empty  (empty),
    .level  (level)
  );

`ifdef LANE_TX_CHECKSUM_EN
  logic [7:0] csum;
  assign csum = seq + frame.center + frame.conf;
`endif

  // Handshake decode, frame-end detection and FIFO pop/push acceptance.
  always_comb begin
    accept = tx_valid && tx_ready;
`ifdef LANE_TX_CHECKSUM_EN
    frame_end = accept && (state == ST_CSUM);
`else
    frame_end = accept && (state == ST_CONF);
`endif
    pop           = !empty && ((state == ST_IDLE) || frame_end);
    wr_acc        = result_valid && (!full || pop);
    tx_valid_next = ((state == ST_IDLE) || frame_end) ? !empty : tx_valid;
    level_next    = level + LW'(wr_acc) - LW'(pop);
  end

  // Frame sequencer: loads the next byte on each accepted handshake and
  // chains straight into the next frame when results are queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      frame    <= '0;
      seq      <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end else if (frame_end) begin
      seq <= seq + 8'd1;
      if (!empty) begin
        frame   <= head;
        tx_data <= SOF_BYTE;
        state   <= ST_SOF;
      end else begin
        tx_valid <= 1'b0;
        state    <= ST_IDLE;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            frame    <= head;
            tx_data  <= SOF_BYTE;
            tx_valid <= 1'b1;
            state    <= ST_SOF;
          end
        end
        ST_SOF: begin
          if (accept) begin
            tx_data <= seq;
            state   <= ST_SEQ;
          end
        end
        ST_SEQ: begin
          if (accept) begin
            tx_data <= frame.center;
            state   <= ST_CENTER;
          end
        end
        ST_CENTER: begin
          if (accept) begin
            tx_data <= frame.conf;
            state   <= ST_CONF;
          end
        end
`ifdef LANE_TX_CHECKSUM_EN
        ST_CONF: begin
          if (accept) begin
            tx_data <= csum;
            state   <= ST_CSUM;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Status outputs: drop pulse, saturating drop counter, registered busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
      busy       <= 1'b0;
    end else begin
      overflow <= result_valid && !wr_acc;
      if (result_valid && !wr_acc && (drop_count != 8'hFF))
        drop_count <= drop_count + 8'd1;
      busy <= tx_valid_next || (level_next != '0);
    end
  end

endmodule

// File: tb/tb_lane_result_tx.sv
// Self-checking bench for lane_result_tx (frame length follows
// LANE_TX_CHECKSUM_EN). Expected bytes are queued at stimulus time and
// compared by an independent monitor on each accepted handshake.
module tb_lane_result_tx;

`ifdef LANE_TX_CHECKSUM_EN
  localparam int FL = 5;
`else
  localparam int FL = 4;
`endif
  localparam int DEPTH = 4;
  localparam logic [7:0] SOF = 8'hA5;

  logic       clk = 1'b0;
  logic       rst;
  logic       result_valid;
  logic [7:0] result_center;
  logic [7:0] result_conf;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       overflow;
  logic [7:0] drop_count;

  lane_result_tx #(
    .FIFO_DEPTH(DEPTH),
    .SOF_BYTE  (SOF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .result_valid (result_valid),
    .result_center(result_center),
    .result_conf  (result_conf),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .busy         (busy),
    .overflow     (overflow),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] sb[$];
  logic [7:0] mseq = 8'd0;
  int         frames_sent = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference frame: SOF, SEQ, CENTER, CONF[, (SEQ+CENTER+CONF) mod 256].
  task automatic add_frame(input logic [7:0] c, input logic [7:0] f);
    int s;
    s = int'(mseq);
    sb.push_back(SOF);
    sb.push_back(mseq);
    sb.push_back(c);
    sb.push_back(f);
    if (FL == 5) sb.push_back(8'((s + int'(c) + int'(f)) % 256));
    mseq = 8'((s + 1) % 256);
    frames_sent++;
  endtask

  // Monitor: compare accepted bytes and check hold-while-stalled.
  logic       hold_pending = 1'b0;
  logic [7:0] hold_data = 8'd0;
  always @(negedge clk) begin
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        chk("hold_valid", 32'(tx_valid), 32'd1);
        chk("hold_data", 32'(tx_data), 32'(hold_data));
      end
      if (tx_valid && tx_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte: got 0x%0h expected no byte at %0t", tx_data, $time);
        end else begin
          chk("tx_byte", 32'(tx_data), 32'(sb.pop_front()));
        end
      end
      hold_pending = tx_valid && !tx_ready;
      hold_data    = tx_data;
    end
  end

  task automatic pulse(input logic [7:0] c, input logic [7:0] f, input bit acc);
    @(posedge clk); #1;
    result_valid  = 1'b1;
    result_center = c;
    result_conf   = f;
    if (acc) add_frame(c, f);
    @(posedge clk); #1;
    result_valid = 1'b0;
    @(negedge clk);
    chk("overflow", 32'(overflow), 32'(!acc));
  endtask

  task automatic wait_valid();
    bit seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (tx_valid) seen = 1;
    end
    chk("wait_valid", 32'(seen), 32'd1);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (!tx_valid && sb.size() == 0) done = 1;
    end
    chk("idle_reached", 32'(done), 32'd1);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    int target;
    int outstanding;
    rst = 1'b1;
    result_valid = 1'b0;
    result_center = 8'd0;
    result_conf = 8'd0;
    tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_drop_count", 32'(drop_count), 32'd0);

    // Single frame, latency N+2.
    tx_ready = 1'b1;
    pulse(8'd15, 8'd200, 1);
    chk("lat_n1_valid", 32'(tx_valid), 32'd0);
    @(negedge clk);
    chk("lat_n2_valid", 32'(tx_valid), 32'd1);
    chk("lat_n2_sof", 32'(tx_data), 32'(SOF));
    wait_idle();

    // Stall while CENTER is presented.
    tx_ready = 1'b0;
    pulse(8'd15, 8'd200, 1);
    wait_valid();
    @(posedge clk); #1 tx_ready = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(tx_valid), 32'd1);
      chk("stall_center", 32'(tx_data), 32'd15);
    end
    @(posedge clk); #1 tx_ready = 1'b1;
    @(negedge clk);
    chk("stall_center_last", 32'(tx_data), 32'd15);
    wait_idle();

    // Overflow: one result sits in the frame register, four fill the FIFO,
    // the sixth is dropped.
    tx_ready = 1'b0;
    for (int i = 1; i <= 6; i++) pulse(8'(i), 8'($urandom_range(0, 255)), i <= 5);
    chk("drop_count_1", 32'(drop_count), 32'd1);
    @(posedge clk); #1 tx_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_valid) cnt++;
      else break;
    end
    chk("burst_no_gap", 32'(cnt), 32'(5 * FL));
    wait_idle();

    // Random traffic across the sequence-number wrap.
    target = frames_sent + 270;
    for (int cyc = 0; cyc < 8000 && frames_sent < target; cyc++) begin
      @(posedge clk); #1;
      tx_ready = ($urandom_range(0, 3) != 0);
      outstanding = (sb.size() + FL - 1) / FL;
      if (outstanding < DEPTH && $urandom_range(0, 1) == 1) begin
        result_valid  = 1'b1;
        result_center = 8'($urandom_range(0, 29));
        result_conf   = 8'($urandom_range(0, 255));
        add_frame(result_center, result_conf);
      end else begin
        result_valid = 1'b0;
      end
      @(negedge clk);
      chk("rand_overflow", 32'(overflow), 32'd0);
    end
    @(posedge clk); #1;
    result_valid = 1'b0;
    tx_ready = 1'b1;
    chk("rand_frames", 32'(frames_sent >= target), 32'd1);
    wait_idle();
    chk("drop_count_kept", 32'(drop_count), 32'd1);

    // Reset while CONF is presented, with a second result queued.
    tx_ready = 1'b0;
    pulse(8'd9, 8'h3C, 1);
    pulse(8'd21, 8'h44, 1);
    wait_valid();
    @(posedge clk); #1 tx_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1 tx_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_conf", 32'(tx_data), 32'h3C);
    @(posedge clk); #1 rst = 1'b1;
    sb.delete();
    mseq = 8'd0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 32'(tx_valid), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_drop", 32'(drop_count), 32'd0);
    tx_ready = 1'b1;
    pulse(8'd7, 8'h11, 1);
    wait_idle();
    repeat (5) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
